// File: rtl/request_dispatcher_pkg.sv
// Shared elevator definitions: dispatcher FSM encoding, default floor count,
// car status field positions and a small arrival helper.
package request_dispatcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PICK  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam int FLOORS_DEFAULT = 10;
    localparam int OBJ_W          = 4;

    // Car status word: [5:2] floor, [1] direction up, [0] moving
    localparam int FLOOR_MSB = 5;
    localparam int FLOOR_LSB = 2;
    localparam int DIR_BIT   = 1;
    localparam int MOVE_BIT  = 0;

    // True when the car is standing still at the given floor
    function automatic logic stopped_at(input logic [5:0] status, input logic [OBJ_W-1:0] floor);
        return !status[MOVE_BIT] && (status[FLOOR_MSB:FLOOR_LSB] == floor);
    endfunction

endpackage

// File: rtl/request_dispatcher_if.sv
// Bus between the request dispatcher and its surroundings (hall buttons,
// car status, car control unit).
//
// obj/objValid: objValid is a one-cycle strobe with no back-pressure; the
// consumer must take obj on the cycle objValid is high. obj stays stable until
// the next strobe, so it may also be read at leisure afterwards.
interface request_dispatcher_if
    import request_dispatcher_pkg::*;
#(
    parameter int FLOORS = FLOORS_DEFAULT
);
    logic [FLOORS-1:0] callBtn;
    logic [5:0]        stateFloorA;
    logic [5:0]        stateFloorB;
    logic [5:0]        stateFloorC;
    logic [OBJ_W-1:0]  obj;
    logic              objValid;
    logic [FLOORS-1:0] pending;

    modport master (
        input  callBtn, stateFloorA, stateFloorB, stateFloorC,
        output obj, objValid, pending
    );

    modport slave (
        output callBtn, stateFloorA, stateFloorB, stateFloorC,
        input  obj, objValid, pending
    );
endinterface

// File: rtl/request_dispatcher_rr_floor_picker.sv
// rr_floor_picker: finds the first eligible floor at or after ptr, wrapping
// from FLOORS-1 back to 0.
module rr_floor_picker
    import request_dispatcher_pkg::*;
#(
    parameter int FLOORS = FLOORS_DEFAULT
) (
    input  logic [FLOORS-1:0] eligible,
    input  logic [OBJ_W-1:0]  ptr,
    output logic [OBJ_W-1:0]  floor,
    output logic              found
);
    // Two copies back to back let the scan run past the top without a modulo
    logic [2*FLOORS-1:0] dbl;
    logic [OBJ_W:0]      idx;

    assign dbl = {eligible, eligible};

    // Scan FLOORS positions starting at ptr; first hit wins
    always_comb begin
        floor = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < FLOORS; i++) begin
            idx = {1'b0, ptr} + (OBJ_W+1)'(i);
            if (!found && dbl[idx]) begin
                found = 1'b1;
                floor = (idx >= (OBJ_W+1)'(FLOORS)) ? OBJ_W'(idx - (OBJ_W+1)'(FLOORS))
                                                     : idx[OBJ_W-1:0];
            end
        end
    end
endmodule

// File: rtl/request_dispatcher.sv
// request_dispatcher: latches hall calls and hands them one at a time to the
// car control unit as obj/objValid, round-robin over the floors.
// Optional watchdog that re-arms stale dispatches: REQUEST_DISPATCHER_WATCHDOG_EN.
module request_dispatcher
    import request_dispatcher_pkg::*;
#(
    parameter int FLOORS      = FLOORS_DEFAULT,
    parameter int HOLD_CYCLES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    request_dispatcher_if.master bus,
    output state_t               state
);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_t            state_q;
    state_t            state_d;
    logic [FLOORS-1:0] pending_q;
    logic [FLOORS-1:0] dispatched_q;
    logic [FLOORS-1:0] arrive;
    logic [FLOORS-1:0] eligible;
    logic [FLOORS-1:0] pick_set;
    logic [OBJ_W-1:0]  obj_q;
    logic [OBJ_W-1:0]  ptr_q;
    logic [OBJ_W-1:0]  pick_floor;
    logic [OBJ_W-1:0]  ptr_next;
    logic              pick_found;
    logic              pick_take;
    logic              any_arrival;
    logic              wd_clear;
    logic [HOLD_W-1:0] hold_q;
    logic              unused_dir;

    // Arrival per floor: any stopped car at that floor; out-of-range floor fields never match
    always_comb begin
        arrive = '0;
        for (int f = 0; f < FLOORS; f++) begin
            arrive[f] = stopped_at(bus.stateFloorA, OBJ_W'(f))
                      | stopped_at(bus.stateFloorB, OBJ_W'(f))
                      | stopped_at(bus.stateFloorC, OBJ_W'(f));
        end
    end

    assign any_arrival = |arrive;
    assign eligible    = pending_q & ~dispatched_q;
    assign unused_dir  = bus.stateFloorA[DIR_BIT] ^ bus.stateFloorB[DIR_BIT] ^ bus.stateFloorC[DIR_BIT];

    rr_floor_picker #(
        .FLOORS (FLOORS)
    ) u_picker (
        .eligible (eligible),
        .ptr      (ptr_q),
        .floor    (pick_floor),
        .found    (pick_found)
    );

    // A pick can come up empty if the only candidate arrived meanwhile
    assign pick_take = (state_q == ST_PICK) && pick_found;
    assign ptr_next  = (pick_floor == OBJ_W'(FLOORS-1)) ? '0 : pick_floor + OBJ_W'(1);

    // One-hot of the floor being dispatched this cycle
    always_comb begin
        pick_set = '0;
        for (int f = 0; f < FLOORS; f++) begin
            if (pick_take && (pick_floor == OBJ_W'(f))) begin
                pick_set[f] = 1'b1;
            end
        end
    end

    // Next-state logic for IDLE -> PICK -> ISSUE -> HOLD -> IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (|eligible) state_d = ST_PICK;
            ST_PICK:  state_d = pick_found ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_d = ST_HOLD;
            ST_HOLD:  if (hold_q == HOLD_W'(HOLD_CYCLES-1)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register, request bookkeeping, round-robin pointer and obj register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            dispatched_q <= '0;
            obj_q        <= '0;
            ptr_q        <= '0;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            // Arrival clear wins over a same-cycle button press or pick
            pending_q    <= (pending_q | bus.callBtn) & ~arrive;
            // A watchdog clear drops stale dispatches but keeps the one picked now
            dispatched_q <= ((wd_clear ? '0 : dispatched_q) | pick_set) & ~arrive;
            hold_q       <= (state_q == ST_HOLD) ? hold_q + HOLD_W'(1) : '0;
            if (pick_take) begin
                obj_q <= pick_floor;
                ptr_q <= ptr_next;
            end
        end
    end

`ifdef REQUEST_DISPATCHER_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT+1);

    logic [WD_W-1:0] wd_q;

    assign wd_clear = (|dispatched_q) && !any_arrival && (wd_q == WD_W'(TIMEOUT-1));

    // Watchdog: counts arrival-free cycles while anything is dispatched
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q <= '0;
        end else if (any_arrival || (dispatched_q == '0) || wd_clear) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + WD_W'(1);
        end
    end
`else
    logic [31:0] unused_timeout;
    logic        unused_arrival;

    // Without the watchdog, dispatched bits clear only via arrival or reset
    assign wd_clear       = 1'b0;
    assign unused_timeout = 32'(TIMEOUT);
    assign unused_arrival = any_arrival;
`endif

    assign bus.obj      = obj_q;
    assign bus.objValid = (state_q == ST_ISSUE);
    assign bus.pending  = pending_q;
    assign state        = state_q;
endmodule

// File: tb/tb_request_dispatcher.sv
// Bench for request_dispatcher: a timestamp-based behavioural model checked
// every cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_request_dispatcher;
    import request_dispatcher_pkg::*;

    localparam int FL   = 10;
    localparam int HOLD = 2;
    localparam int TMO  = 64;
    localparam logic [5:0] CAR_MOVING  = 6'b000001;
    localparam logic [5:0] CAR_AT0     = 6'b000000;
    localparam logic [5:0] CAR_AT3     = 6'b001100;
    localparam logic [5:0] CAR_AT5     = 6'b010100;
    localparam logic [5:0] CAR_AT12    = 6'b110000;

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   rst;
    state_t dbg_state;

    request_dispatcher_if #(.FLOORS(FL)) bus();

    request_dispatcher #(
        .FLOORS      (FL),
        .HOLD_CYCLES (HOLD),
        .TIMEOUT     (TMO)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // ---------------- scoreboard ----------------
    int         vectors     = 0;
    int         miscompares = 0;
    int         strobe_cnt  = 0;
    logic [3:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Busy periods are tracked as cycle timestamps: an idle cycle that sees an
    // eligible floor schedules a pick on the next cycle; a successful pick
    // strobes one cycle later and the dispatcher is idle again HOLD cycles after that.
    logic [FL-1:0] m_pend = '0;
    logic [FL-1:0] m_disp = '0;
    int            m_ptr = 0;
    int            m_obj = 0;
    int            m_cyc = 0;
    int            m_free_at = 0;
    int            m_pick_at = -1;
    int            m_wd = 0;
    bit            m_valid = 1'b0;
    bit            model_live = 1'b0;

    function automatic logic [FL-1:0] arrivals(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
        logic [5:0]    cars[3];
        logic [FL-1:0] r;
        r = '0;
        cars[0] = a;
        cars[1] = b;
        cars[2] = c;
        foreach (cars[k]) begin
            if (cars[k][0] == 1'b0 && int'(cars[k][5:2]) < FL) r |= FL'(1) << cars[k][5:2];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        logic [FL-1:0] arr;
        logic [FL-1:0] elig;
        logic [FL-1:0] set_v;
        bit            found;
        int            f;
        if (rst) begin
            m_pend     = '0;
            m_disp     = '0;
            m_ptr      = 0;
            m_obj      = 0;
            m_valid    = 1'b0;
            m_wd       = 0;
            m_pick_at  = -1;
            m_free_at  = m_cyc + 1;
            model_live = 1'b1;
        end else begin
            arr     = arrivals(bus.stateFloorA, bus.stateFloorB, bus.stateFloorC);
            elig    = m_pend & ~m_disp;
            set_v   = '0;
            m_valid = 1'b0;
            if (m_pick_at == m_cyc) begin
                found = 1'b0;
                for (int k = 0; k < FL; k++) begin
                    f = (m_ptr + k) % FL;
                    if (!found && elig[f]) begin
                        found    = 1'b1;
                        m_obj    = f;
                        m_ptr    = (f + 1) % FL;
                        set_v[f] = 1'b1;
                    end
                end
                if (found) begin
                    m_valid   = 1'b1;
                    exp_q.push_back(4'(m_obj));
                    m_free_at = m_cyc + 2 + HOLD;
                end else begin
                    m_free_at = m_cyc + 1;
                end
                m_pick_at = -1;
            end else if (m_pick_at < 0 && m_cyc >= m_free_at && elig != '0) begin
                m_pick_at = m_cyc + 1;
            end
`ifdef REQUEST_DISPATCHER_WATCHDOG_EN
            if (arr != '0 || m_disp == '0) begin
                m_wd = 0;
            end else if (m_wd == TMO - 1) begin
                m_wd   = 0;
                m_disp = '0;
            end else begin
                m_wd++;
            end
`endif
            m_pend = (m_pend | bus.callBtn) & ~arr;
            m_disp = (m_disp | set_v) & ~arr;
        end
        m_cyc++;
    end

    // Compare DUT against the model on every cycle, away from the active edge
    always @(negedge clk) begin
        if (model_live) begin
            check("objValid", 32'(bus.objValid), 32'(m_valid));
            check("obj", 32'(bus.obj), 32'(m_obj));
            check("pending", 32'(bus.pending), 32'(m_pend));
            if (bus.objValid) begin
                strobe_cnt++;
                check("strobe_queued", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("strobe_obj", 32'(bus.obj), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_cars(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
        bus.stateFloorA = a;
        bus.stateFloorB = b;
        bus.stateFloorC = c;
    endtask

    task automatic do_reset(input logic [5:0] car);
        rst         = 1'b1;
        bus.callBtn = '0;
        set_cars(car, car, car);
        step();
        rst = 1'b0;
        check("rst_pending", 32'(bus.pending), 32'd0);
        check("rst_obj", 32'(bus.obj), 32'd0);
        check("rst_objValid", 32'(bus.objValid), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    endtask

    task automatic press(input logic [FL-1:0] btn);
        bus.callBtn = btn;
        step();
        bus.callBtn = '0;
    endtask

    task automatic wait_strobe(input string name, input int limit, output logic [3:0] o, output int waited);
        waited = 0;
        while (waited < limit && !bus.objValid) begin
            step();
            waited++;
        end
        check({name, "_seen"}, 32'(bus.objValid), 32'd1);
        o = bus.obj;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [3:0] o;
        int         waited;
        int         s0;

        rst         = 1'b1;
        bus.callBtn = '0;
        set_cars(CAR_AT0, CAR_AT0, CAR_AT0);

        // Call at a floor where a car already stands is never latched
        do_reset(CAR_AT0);
        press(10'h001);
        check("call0_pending", 32'(bus.pending), 32'd0);
        s0 = strobe_cnt;
        step(8);
        check("call0_no_strobe", 32'(strobe_cnt), 32'(s0));

        // Single call at floor 3: latch at 1, strobe at 3, obj held through HOLD and IDLE
        press(10'h008);
        check("call3_pending_c1", 32'(bus.pending), 32'h008);
        step();
        check("call3_state_c2", 32'(dbg_state), 32'(ST_PICK));
        step();
        check("call3_valid_c3", 32'(bus.objValid), 32'd1);
        check("call3_obj_c3", 32'(bus.obj), 32'd3);
        step();
        check("call3_valid_c4", 32'(bus.objValid), 32'd0);
        check("call3_obj_c4", 32'(bus.obj), 32'd3);
        step();
        check("call3_obj_c5", 32'(bus.obj), 32'd3);
        step();
        check("call3_state_c6", 32'(dbg_state), 32'(ST_IDLE));
        check("call3_obj_c6", 32'(bus.obj), 32'd3);
        set_cars(CAR_AT3, CAR_AT0, CAR_AT0);
        step();
        set_cars(CAR_AT0, CAR_AT0, CAR_AT0);
        check("call3_arrival_clear", 32'(bus.pending), 32'd0);

        // Floors 9 and 2 together: 2 then 9, then pointer wraps to 0
        do_reset(CAR_MOVING);
        press(10'h204);
        wait_strobe("rr_first", 10, o, waited);
        check("rr_first_obj", 32'(o), 32'd2);
        step();
        wait_strobe("rr_second", 10, o, waited);
        check("rr_second_obj", 32'(o), 32'd9);
        check("rr_strobe_gap", 32'(waited + 1), 32'(3 + HOLD));
        press(10'h021);
        wait_strobe("rr_wrap", 20, o, waited);
        check("rr_wrap_obj", 32'(o), 32'd0);
        step();
        wait_strobe("rr_after_wrap", 20, o, waited);
        check("rr_after_wrap_obj", 32'(o), 32'd5);

        // Arrival after issue clears floor 5; a stopped car at floor 12 is ignored
        do_reset(CAR_MOVING);
        set_cars(CAR_MOVING, CAR_MOVING, CAR_AT12);
        press(10'h020);
        wait_strobe("arr_issue", 10, o, waited);
        check("arr_issue_obj", 32'(o), 32'd5);
        set_cars(CAR_MOVING, CAR_AT5, CAR_AT12);
        step();
        set_cars(CAR_MOVING, CAR_MOVING, CAR_AT12);
        check("arr_pending_clear", 32'(bus.pending), 32'd0);
        s0 = strobe_cnt;
        step(15);
        check("arr_no_reissue", 32'(strobe_cnt), 32'(s0));
        press(10'h020);
        wait_strobe("arr_redispatch", 10, o, waited);
        check("arr_redispatch_obj", 32'(o), 32'd5);

        // Reset in the middle of HOLD; buttons during reset are dropped
        do_reset(CAR_MOVING);
        press(10'h0F0);
        wait_strobe("hold_issue", 10, o, waited);
        check("hold_issue_obj", 32'(o), 32'd4);
        step();
        check("hold_state", 32'(dbg_state), 32'(ST_HOLD));
        check("hold_pending", 32'(bus.pending), 32'h0F0);
        rst         = 1'b1;
        bus.callBtn = 10'h00F;
        step();
        check("midrst_pending", 32'(bus.pending), 32'd0);
        check("midrst_obj", 32'(bus.obj), 32'd0);
        check("midrst_valid", 32'(bus.objValid), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        press(10'h002);
        check("post_rst_latch", 32'(bus.pending), 32'h002);

        // Dispatched floor 7 with no arrival ever
        do_reset(CAR_MOVING);
        press(10'h080);
        wait_strobe("wd_issue", 10, o, waited);
        check("wd_issue_obj", 32'(o), 32'd7);
        step();
`ifdef REQUEST_DISPATCHER_WATCHDOG_EN
        wait_strobe("wd_reissue", 200, o, waited);
        check("wd_reissue_obj", 32'(o), 32'd7);
        check("wd_reissue_gap", 32'(waited + 1), 32'd66);
`else
        s0 = strobe_cnt;
        step(100);
        check("no_wd_reissue", 32'(strobe_cnt), 32'(s0));
        check("no_wd_pending", 32'(bus.pending), 32'h080);
`endif

        step(5);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
